// File: rtl/pe_nic.sv
// Network interface between a processing element and the router PE port.
// Processor sees one ejection buffer, one injection buffer and their status bits.
module pe_nic #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] d_in,
    output logic [DATA_WIDTH-1:0] d_out,
    input  logic                  nicEn,
    input  logic                  nicWrEn,
    output logic                  net_so,
    output logic [DATA_WIDTH-1:0] net_do,
    input  logic                  net_ro,
    input  logic                  net_si,
    input  logic [DATA_WIDTH-1:0] net_di,
    output logic                  net_ri,
    input  logic                  net_polarity
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } buf_state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_IN_BUF   = ADDR_WIDTH'(0);
    localparam logic [ADDR_WIDTH-1:0] ADDR_IN_STAT  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_OUT_BUF  = ADDR_WIDTH'(2);
    localparam logic [ADDR_WIDTH-1:0] ADDR_OUT_STAT = ADDR_WIDTH'(3);

    buf_state_t            in_state;
    buf_state_t            out_state;
    logic [DATA_WIDTH-1:0] in_buf;
    logic [DATA_WIDTH-1:0] out_buf;
    logic                  rd_en;
    logic                  wr_en;
    logic                  in_full;
    logic                  out_full;

    assign rd_en    = nicEn & ~nicWrEn;
    assign wr_en    = nicEn & nicWrEn;
    assign in_full  = (in_state == FULL);
    assign out_full = (out_state == FULL);

    assign net_ri = ~in_full;
    assign net_do = out_buf;
    // A packet may only leave while the router is on its VC's phase.
    assign net_so = out_full & (out_buf[DATA_WIDTH-1] == net_polarity);

    always_ff @(posedge clk) begin
        if (!reset) begin
            in_state  <= EMPTY;
            out_state <= EMPTY;
            in_buf    <= '0;
            out_buf   <= '0;
            d_out     <= '0;
        end else begin
            case (in_state)
                EMPTY: if (net_si) begin
                    in_buf   <= net_di;
                    in_state <= FULL;
                end
                FULL: if (rd_en && addr == ADDR_IN_BUF) in_state <= EMPTY;
                default: in_state <= EMPTY;
            endcase

            // A write that lands on the transfer edge still sees FULL and is dropped.
            case (out_state)
                EMPTY: if (wr_en && addr == ADDR_OUT_BUF) begin
                    out_buf   <= d_in;
                    out_state <= FULL;
                end
                FULL: if (net_so && net_ro) out_state <= EMPTY;
                default: out_state <= EMPTY;
            endcase

            if (rd_en) begin
                case (addr)
                    ADDR_IN_BUF:   d_out <= in_buf;
                    ADDR_IN_STAT:  d_out <= {{(DATA_WIDTH-1){1'b0}}, in_full};
                    ADDR_OUT_STAT: d_out <= {{(DATA_WIDTH-1){1'b0}}, out_full};
                    default:       d_out <= d_out;
                endcase
            end
        end
    end

endmodule

// File: doc/pe_nic.md
Name: pe_nic

Overview:
- Network interface controller between the processing element and the PE port of gold_router.
- Gives the processor a 4-register memory-mapped view:
  - one 64-bit ejection (input) buffer plus its status;
  - one 64-bit injection (output) buffer plus its status.
- Router side uses the ready/valid channel (si/di/ri, so/do/ro).
- Injection is gated by router polarity so a packet only leaves on its VC's phase.

Parameters:
- DATA_WIDTH, 64, packet and processor data width; bit [DATA_WIDTH-1] is the VC bit.
- ADDR_WIDTH, 2, processor register address width.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-low reset; reset==0 at a posedge initialises all state.
- addr  in  ADDR_WIDTH  register select:
  - 0 = input buffer (read);
  - 1 = input status (read);
  - 2 = output buffer (write);
  - 3 = output status (read).
- d_in  in  DATA_WIDTH  processor write data.
- d_out  out  DATA_WIDTH  processor read data (registered).
- nicEn  in  1  processor access enable.
- nicWrEn  in  1  1 = write, 0 = read; qualified by nicEn.
- net_so  out  1  send to router pe_si.
- net_do  out  DATA_WIDTH  packet to router pe_di.
- net_ro  in  1  router pe_ri.
- net_si  in  1  router pe_so.
- net_di  in  DATA_WIDTH  router pe_do.
- net_ri  out  1  ready to router pe_ro.
- net_polarity  in  1  router polarity.

Behaviour:
- Reset (reset==0 at posedge):
  - in_full=0, out_full=0, in_buf=0, out_buf=0, d_out=0.
  - Resulting outputs: net_so=0, net_do=0, net_ri=1.
  - Reset mid-transfer discards both buffers; no partial state survives.
- Ejection path:
  - net_ri = ~in_full (combinational).
  - Capture: at posedge with net_si & net_ri, in_buf<=net_di and in_full<=1.
  - An arrival while full cannot occur (net_ri=0); net_si while net_ri=0 is ignored.
- Processor reads (nicEn & ~nicWrEn), d_out valid the cycle after the access edge (1-cycle latency):
  - addr0: d_out<=in_buf; in_full<=0 at the same edge. Reading while empty returns stale in_buf and leaves in_full=0.
  - addr1: d_out<={zeros, in_full}.
  - addr3: d_out<={zeros, out_full}.
  - addr2: d_out unchanged.
- Other cycles:
  - d_out holds when nicEn=0 or on a write.
  - Writes to addr 0, 1, 3 are ignored.
- Injection path:
  - Write accept: write to addr2 with out_full=0 gives out_buf<=d_in, out_full<=1.
  - Write to addr2 with out_full=1 is dropped; the buffer is not overwritten.
  - net_do = out_buf (registered value).
  - net_so = out_full & (out_buf[DATA_WIDTH-1] == net_polarity).
- Transfer: at posedge with net_so & net_ro, out_full<=0 and out_buf keeps its value.
- Simultaneous events:
  - Write and transfer at the same edge: write sees out_full=1 and is dropped. Software must poll addr3.
  - Read of addr0 and net_si at the same edge with in_full=1: read clears in_full; the arrival is not captured (net_ri was 0). net_ri rises the next cycle.
  - Read of addr1 at the capture edge returns the pre-edge in_full.
- Stall:
  - net_ro=0 or a polarity mismatch holds out_full=1 and out_buf stable indefinitely.
  - net_so toggles with polarity while full.
- State per direction: two-state EMPTY/FULL machine.
  - EMPTY->FULL on write/capture.
  - FULL->EMPTY on transfer/read.

Test Plan:
- Reset then idle:
  - Hold reset=0 for 4 cycles, then release.
  - Required: d_out=0, net_so=0, net_ri=1; addr1 and addr3 reads return 0.
- Injection on matching phase:
  - Write 64'h2021AA55FEEDBEEF to addr2 (VC=0).
  - Required: net_so=1 only while net_polarity=0, with net_do equal to that value.
  - With net_ro=1, out_full clears after one transfer edge; addr3 reads 0.
- Full-drop:
  - With net_ro=0, write A=64'h1 then B=64'h2 to addr2.
  - Required: net_do stays 64'h1; addr3 reads 1.
  - After net_ro=1 on the VC-0 phase, exactly one transfer of 64'h1.
- Ejection:
  - Drive net_si=1 with net_di=64'hA000_0000_0000_0055 for 3 cycles.
  - Required: captured once; net_ri=0 from the next cycle.
  - addr1 reads 1; addr0 read returns 64'hA000000000000055 one cycle later; net_ri returns to 1.
- Simultaneous write and transfer:
  - Write C to addr2 on the same edge out_full clears.
  - Required: C dropped; addr3 reads 0 afterwards.
- Reset mid-operation:
  - Fill both buffers, assert reset=0 for one cycle.
  - Required: net_so=0, net_ri=1, status reads 0, no transfer of the old packet.
